// File: rtl/bin_bcd_display_seq_pkg.sv
// Shared types and constants for the serial binary-to-BCD display driver:
// FSM encoding, seven-segment patterns ({g,f,e,d,c,b,a}) and counter sizing.
package bin_bcd_display_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_bcd_display_seq_if.sv
// Request/result bundle between a binary datapath (master) and the display driver (slave).
// No backpressure: start is only honoured while busy is low.
interface bin_bcd_display_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  valid;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     digit_on;
    logic [7*DIGITS-1:0]   seg;

    modport master (output start, bin, input busy, valid, ovf, bcd, digit_on, seg);
    modport slave  (input start, bin, output busy, valid, ovf, bcd, digit_on, seg);
endinterface

// File: rtl/bin_bcd_display_seq_bcd_dabble_digit.sv
// Double-dabble correction for one BCD digit: values 5..9 get +3 before the shift.
// Purely combinational, zero latency, no flow control.
module bcd_dabble_digit (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);
    assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;
endmodule

// File: rtl/bin_bcd_display_seq.sv
// Serial double-dabble binary-to-BCD converter with seven-segment drive; result after WIDTH+1 cycles.
// Starts arriving while busy are dropped; outputs hold until the next completed conversion.
module bin_bcd_display_seq
    import bin_bcd_display_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bin_bcd_display_seq_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam int BW = 4 * DIGITS;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]       work_q, work_d, work_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0]   digit_on_q, digit_on_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;

    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       bcd_v;
    logic [DIGITS-1:0]   on_v;
    logic [7*DIGITS-1:0] seg_v;
    logic                lead_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_dig (
            .d_in  (work_q[4*g +: 4]),
            .d_out (work_adj[4*g +: 4])
        );
    end

    assign shifted = {work_adj, shreg_q} << 1;

    // Display view of the finished work digits; leading zeros scanned from the top digit down.
    always_comb begin
        bcd_v     = work_q;
        on_v      = '0;
        seg_v     = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (work_q[4*i +: 4] == 4'd0);
            on_v[i]   = !((BLANK_LZ != 0) && lead_zero && (i > 0));
            seg_v[7*i +: 7] = on_v[i] ? seg_of(work_q[4*i +: 4]) : SEG_BLANK;
        end
        if (sticky_q) begin
            bcd_v = {DIGITS{4'h9}};
            on_v  = '1;
            seg_v = {DIGITS{SEG_DASH}};
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        digit_on_d = digit_on_q;
        seg_d      = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shreg_d  = bus.bin;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d   = shifted[BW+WIDTH-1 : WIDTH];
                shreg_d  = shifted[WIDTH-1:0];
                sticky_d = sticky_q | work_adj[BW-1];
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d    = 1'b1;
                ovf_d      = sticky_q;
                bcd_d      = bcd_v;
                digit_on_d = on_v;
                seg_d      = seg_v;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            digit_on_q <= '0;
            seg_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            digit_on_q <= digit_on_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.valid    = valid_q;
    assign bus.ovf      = ovf_q;
    assign bus.bcd      = bcd_q;
    assign bus.digit_on = digit_on_q;
    assign bus.seg      = seg_q;

endmodule

// File: tb/tb_bin_bcd_display_seq.sv
// Scoreboard bench: four configurations of bin_bcd_display_seq checked against a decimal model.
module tb_bin_bcd_display_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8;
    logic [7:0] bin8;
    logic       start10;
    logic [9:0] bin10;

    bin_bcd_display_seq_if #(.WIDTH(8),  .DIGITS(3)) if_a ();
    bin_bcd_display_seq_if #(.WIDTH(8),  .DIGITS(3)) if_b ();
    bin_bcd_display_seq_if #(.WIDTH(8),  .DIGITS(2)) if_c ();
    bin_bcd_display_seq_if #(.WIDTH(10), .DIGITS(3)) if_d ();

    assign if_a.start = start8;  assign if_a.bin = bin8;
    assign if_b.start = start8;  assign if_b.bin = bin8;
    assign if_c.start = start8;  assign if_c.bin = bin8;
    assign if_d.start = start10; assign if_d.bin = bin10;

    bin_bcd_display_seq #(.WIDTH(8),  .DIGITS(3), .BLANK_LZ(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    bin_bcd_display_seq #(.WIDTH(8),  .DIGITS(3), .BLANK_LZ(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    bin_bcd_display_seq #(.WIDTH(8),  .DIGITS(2), .BLANK_LZ(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
    bin_bcd_display_seq #(.WIDTH(10), .DIGITS(3), .BLANK_LZ(1)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t q_d[$];

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int v, input int nd, input bit blank,
                                  output logic [31:0] bcd, output logic [31:0] seg,
                                  output logic [31:0] on, output logic ovf);
        int lim;
        int r;
        int hi;
        int d [8];
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ovf = (v >= lim);
        r   = v;
        hi  = 0;
        bcd = '0;
        seg = '0;
        on  = '0;
        for (int i = 0; i < nd; i++) begin
            d[i] = r % 10;
            r    = r / 10;
            if (d[i] != 0) hi = i;
        end
        for (int i = 0; i < nd; i++) begin
            if (ovf) begin
                bcd[4*i +: 4] = 4'h9;
                seg[7*i +: 7] = 7'h40;
                on[i]         = 1'b1;
            end else begin
                bcd[4*i +: 4] = d[i][3:0];
                on[i]         = !blank || (i <= hi);
                seg[7*i +: 7] = on[i] ? segtab[d[i]] : 7'h00;
            end
        end
    endfunction

    task automatic check_out(input string n, input bit have, input exp_t e, input int nd,
                             input bit blank, input int lat, input logic ovf, input logic [31:0] bcd,
                             input logic [31:0] seg, input logic [31:0] on, input logic busy);
        logic [31:0] x_bcd, x_seg, x_on;
        logic        x_ovf;
        check_eq({n, ".expected_valid"}, 32'(have), 32'd1);
        if (!have) return;
        model(e.val, nd, blank, x_bcd, x_seg, x_on, x_ovf);
        check_eq({n, ".latency"}, 32'(cyc - e.t), 32'(lat));
        check_eq({n, ".ovf"}, 32'(ovf), 32'(x_ovf));
        check_eq({n, ".bcd"}, bcd, x_bcd);
        check_eq({n, ".seg"}, seg, x_seg);
        check_eq({n, ".digit_on"}, on, x_on);
        check_eq({n, ".busy_at_valid"}, 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e; bit h;
        if (if_a.valid) begin
            h = (q_a.size() > 0);
            if (h) e = q_a.pop_front();
            check_out("a", h, e, 3, 1'b1, 10, if_a.ovf, if_a.bcd, if_a.seg, if_a.digit_on, if_a.busy);
        end
    end
    always @(negedge clk) begin : mon_b
        exp_t e; bit h;
        if (if_b.valid) begin
            h = (q_b.size() > 0);
            if (h) e = q_b.pop_front();
            check_out("b", h, e, 3, 1'b0, 10, if_b.ovf, if_b.bcd, if_b.seg, if_b.digit_on, if_b.busy);
        end
    end
    always @(negedge clk) begin : mon_c
        exp_t e; bit h;
        if (if_c.valid) begin
            h = (q_c.size() > 0);
            if (h) e = q_c.pop_front();
            check_out("c", h, e, 2, 1'b1, 10, if_c.ovf, if_c.bcd, if_c.seg, if_c.digit_on, if_c.busy);
        end
    end
    always @(negedge clk) begin : mon_d
        exp_t e; bit h;
        if (if_d.valid) begin
            h = (q_d.size() > 0);
            if (h) e = q_d.pop_front();
            check_out("d", h, e, 3, 1'b1, 12, if_d.ovf, if_d.bcd, if_d.seg, if_d.digit_on, if_d.busy);
        end
    end

    task automatic push8(input int v);
        exp_t e;
        e.val = v;
        e.t   = cyc;
        q_a.push_back(e);
        q_b.push_back(e);
        q_c.push_back(e);
    endtask

    task automatic go8(input int v);
        start8 = 1'b1;
        bin8   = v[7:0];
        push8(v);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go10(input int v);
        exp_t e;
        start10 = 1'b1;
        bin10   = v[9:0];
        e.val   = v;
        e.t     = cyc;
        q_d.push_back(e);
        @(negedge clk);
        start10 = 1'b0;
    endtask

    task automatic check_dark(input string n);
        check_eq({n, ".busy"},     32'(if_a.busy),     32'd0);
        check_eq({n, ".valid"},    32'(if_a.valid),    32'd0);
        check_eq({n, ".ovf"},      32'(if_a.ovf),      32'd0);
        check_eq({n, ".bcd"},      32'(if_a.bcd),      32'd0);
        check_eq({n, ".seg"},      32'(if_a.seg),      32'd0);
        check_eq({n, ".digit_on"}, 32'(if_a.digit_on), 32'd0);
        check_eq({n, ".d_seg"},    32'(if_d.seg),      32'd0);
    endtask

    int vals [10] = '{255, 19, 0, 7, 99, 200, 100, 9, 10, 250};

    initial begin
        start8  = 1'b1;
        bin8    = 8'd5;
        start10 = 1'b0;
        bin10   = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_dark("reset");

        // Release with start already asserted: accepted at the first edge.
        rst_n = 1'b1;
        go8(5);
        repeat (9) @(negedge clk);

        foreach (vals[k]) begin
            go8(vals[k]);
            repeat (9) @(negedge clk);
        end

        // Repeated starts while busy must be dropped; the one during valid is taken.
        start8 = 1'b1;
        bin8   = 8'd42;
        push8(42);
        repeat (9) begin
            @(negedge clk);
            bin8 = 8'd77;
        end
        @(negedge clk);
        push8(77);
        @(negedge clk);
        start8 = 1'b0;
        repeat (9) @(negedge clk);

        // Abort a conversion at the fourth shift edge.
        go8(255);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        q_c.delete();
        @(negedge clk);
        check_dark("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        go8(128);
        repeat (9) @(negedge clk);

        for (int v = 0; v < 1024; v++) begin
            go10(v);
            repeat (11) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check_eq("a.pending", 32'(q_a.size()), 32'd0);
        check_eq("b.pending", 32'(q_b.size()), 32'd0);
        check_eq("c.pending", 32'(q_c.size()), 32'd0);
        check_eq("d.pending", 32'(q_d.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_bcd_display_seq.md
# bin_bcd_display_seq

Parametrised sequential binary-to-decimal display driver: converts a WIDTH-bit unsigned value into DIGITS BCD digits by serial shift-add-3 (double dabble), then drives one seven-segment pattern per digit with optional leading-zero blanking and an overflow indication. It generalises the fixed two-digit 0–19 display path to arbitrary width and digit count, and trades latency for area. It sits between a binary datapath (counter/comparator result) and the multi-digit display.

## Interface
- WIDTH, 8: binary input width, ≥ 1
- DIGITS, 3: number of decimal digits / displays, ≥ 1
- BLANK_LZ, 1: 1 = blank leading zero digits, 0 = show all digits
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  request conversion of bin; sampled only in IDLE
- bin  input  WIDTH  unsigned value, captured on the accepting edge
- busy  output  1  conversion in progress
- valid  output  1  one-cycle pulse: new result on bcd/seg/digit_on/ovf
- ovf  output  1  value exceeds 10^DIGITS − 1
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
- digit_on  output  DIGITS  per-digit display enable (1 = lit)
- seg  output  7*DIGITS  per-digit segments, digit i in [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-high

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 → capture bin into shift reg, clear BCD work regs and sticky ovf, load bit counter = WIDTH, go SHIFT, busy=1.
- SHIFT, per cycle: every work digit ≥ 5 gets +3 (4-bit add, no carry out), then {work digits, shift reg} shift left by one; the bit leaving the top digit ORs into the sticky ovf. Counter decrements; at counter reaching 0 (after exactly WIDTH shifts) go DONE.
- DONE: register outputs, valid=1 for one cycle, busy=0, go IDLE.
- Output update at DONE: ovf ← sticky; bcd ← work digits; if ovf, every digit shows dash (7'h40), digit_on all 1s, bcd forced to all 9s.
- Non-overflow segments: 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F; codes A–F cannot occur.
- Blanking (BLANK_LZ=1, no ovf): digit i>0 is blank (seg 7'h00, digit_on[i]=0) when digits i..DIGITS−1 are all zero; digit 0 always lit. BLANK_LZ=0: digit_on all 1s.
- Outputs hold their last value until the next DONE; they never show intermediate work values.
- start while busy (SHIFT/DONE) is ignored, not queued; bin changes after capture have no effect.

## Timing
- Accepting edge E0 (start=1 in IDLE). Shift edges E1..E_WIDTH. Outputs and valid update at E_WIDTH+1; latency WIDTH+1 cycles.
- busy high after E0 through E_WIDTH+1 (falls at same edge valid rises).
- Back-to-back: start high during the valid cycle is accepted at the following edge; throughput one conversion per WIDTH+2 cycles.
- Reset (any time, incl. mid-SHIFT): FSM → IDLE; busy, valid, ovf = 0; bcd = 0; seg = 0; digit_on = 0 (display dark until first result). No valid pulse for an aborted conversion.
- Release of rst_n with start already high: accepted at the first rising edge after release.

## Structure
- Shared package/include: FSM state encodings, segment constants (digit patterns, SEG_BLANK=7'h00, SEG_DASH=7'h40), counter width = clog2(WIDTH+1).
- One sub-module: bcd_dabble_digit — 4-bit digit correction (≥5 → +3), instantiated DIGITS times in a generate loop. Segment lookup is a function in the package, not a module.

## Test plan
- WIDTH=8, DIGITS=3: bin=255, start one cycle → valid exactly 9 cycles later, bcd=12'h255, seg digits {5B,6D,6D}, digit_on=3'b111, ovf=0.
- bin=19 → bcd=12'h019, digit_on=3'b011, seg[20:14]=00; bin=0 → bcd=000, digit_on=3'b001, seg digit0=3F; BLANK_LZ=0 with bin=7 → digit_on=111, segs {3F,3F,07}.
- WIDTH=8, DIGITS=2: bin=99 → bcd=8'h99, ovf=0; bin=200 → ovf=1, both digits 40, bcd=8'h99, digit_on=2'b11.
- Start pulse with bin=42, then start=1 with bin=77 every cycle while busy → single valid, bcd=042; next accepted start after valid yields 077.
- rst_n low at E4 of a 255 conversion → all outputs 0, no valid; new start with bin=128 → bcd=128 after 9 cycles.
- Exhaustive sweep WIDTH=10, DIGITS=3 (0–1023) against reference model: values ≥1000 → ovf=1, all others exact BCD and blanking.
